// File: rtl/branch_pkg.sv
// Shared constants and helpers for the branch predict unit: opcodes, counter
// reset pattern and PC-to-table-index extraction.
package branch_pkg;

  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_BLEZ = 6'b000110;
  localparam logic [5:0] OP_BGTZ = 6'b000111;

  // Weakly-not-taken, left-aligned: shift right by (32 - CTR_BITS) to get the
  // MSB=0, rest=1 pattern for any counter width up to 32.
  localparam logic [31:0] CTR_WEAK_NT = 32'h7FFF_FFFF;

  // Word-aligned index: drops PC[1:0] and keeps log2(depth) bits above them.
  function automatic logic [63:0] pc_index(input logic [63:0] pc,
                                           input int unsigned depth);
    return (pc >> 2) & (64'(depth) - 64'd1);
  endfunction

endpackage

// File: rtl/branch_predict_unit_sat_counter.sv
// CTR_BITS-wide saturating up/down counter that resets to weakly-not-taken.
module sat_counter
  import branch_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o
);

  localparam logic [W-1:0] RST_VAL = W'(CTR_WEAK_NT >> (32 - W));

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolution plus a PC-indexed table of saturating counters for fetch
// prediction. Optional BRANCH_STATS_EN adds saturating resolve/mispredict counters.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int CTR_BITS   = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] fetch_Pc,
  output logic                  predict_Taken,
  input  logic                  branch,
  input  logic                  resolve_Valid,
  input  logic [5:0]            op_Code,
  input  logic [DATA_WIDTH-1:0] ula_Result,
  input  logic [DATA_WIDTH-1:0] resolve_Pc,
  input  logic [DATA_WIDTH-1:0] resolve_Target,
  input  logic                  resolve_Pred,
  output logic                  branch_Result,
  output logic                  mispredict,
  output logic [DATA_WIDTH-1:0] redirect_Pc
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]           stat_Branches,
  output logic [31:0]           stat_Mispredicts
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [IDX_W-1:0]      fetch_idx, upd_idx;
  logic [DEPTH-1:0]      ctr_msb;
  logic                  op_ok, cond, fire;
  logic                  mispredict_q, mispredict_d;
  logic [DATA_WIDTH-1:0] redirect_q, redirect_d;

  assign fetch_idx = IDX_W'(pc_index(64'(fetch_Pc), DEPTH));
  assign upd_idx   = IDX_W'(pc_index(64'(resolve_Pc), DEPTH));

  always_comb begin
    op_ok = 1'b1;
    cond  = 1'b0;
    case (op_Code)
      OP_BEQ:  cond = (ula_Result == '0);
      OP_BNE:  cond = (ula_Result != '0);
      OP_BLEZ: cond = ($signed(ula_Result) <= 0);
      OP_BGTZ: cond = ($signed(ula_Result) > 0);
      default: op_ok = 1'b0;
    endcase
  end

  assign fire          = branch && resolve_Valid && op_ok;
  assign branch_Result = fire && cond;

  for (genvar i = 0; i < DEPTH; i++) begin : g_table
    logic             hit;
    logic [CTR_BITS-1:0] cnt;
    assign hit = fire && (upd_idx == IDX_W'(i));
    sat_counter #(.W(CTR_BITS)) u_ctr (
      .clk_i   (clock),
      .rst_ni  (reset_n),
      .inc_i   (hit && branch_Result),
      .dec_i   (hit && !branch_Result),
      .count_o (cnt)
    );
    assign ctr_msb[i] = cnt[CTR_BITS-1];
  end

  // Table read is pre-update: the new counter value is visible next cycle.
  assign predict_Taken = ctr_msb[fetch_idx];

  // redirect only moves on a mispredict so it holds while mispredict is low.
  always_comb begin
    mispredict_d = fire && (branch_Result != resolve_Pred);
    redirect_d   = redirect_q;
    if (mispredict_d) begin
      redirect_d = branch_Result ? resolve_Target : (resolve_Pc + DATA_WIDTH'(4));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
    end else begin
      mispredict_q <= mispredict_d;
      redirect_q   <= redirect_d;
    end
  end

  assign mispredict  = mispredict_q;
  assign redirect_Pc = redirect_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_br_q, stat_mis_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else begin
      if (fire && (stat_br_q != '1)) stat_br_q <= stat_br_q + 32'd1;
      if (mispredict_d && (stat_mis_q != '1)) stat_mis_q <= stat_mis_q + 32'd1;
    end
  end

  assign stat_Branches    = stat_br_q;
  assign stat_Mispredicts = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: directed vectors with hand-computed
// expectations; define BRANCH_STATS_EN to also check the statistics counters.
module tb_branch_predict_unit;
  import branch_pkg::*;

  logic        clock;
  logic        reset_n;
  logic [31:0] fetch_Pc;
  logic        predict_Taken;
  logic        branch;
  logic        resolve_Valid;
  logic [5:0]  op_Code;
  logic [31:0] ula_Result;
  logic [31:0] resolve_Pc;
  logic [31:0] resolve_Target;
  logic        resolve_Pred;
  logic        branch_Result;
  logic        mispredict;
  logic [31:0] redirect_Pc;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_Branches;
  logic [31:0] stat_Mispredicts;
`endif

  branch_predict_unit dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .fetch_Pc       (fetch_Pc),
    .predict_Taken  (predict_Taken),
    .branch         (branch),
    .resolve_Valid  (resolve_Valid),
    .op_Code        (op_Code),
    .ula_Result     (ula_Result),
    .resolve_Pc     (resolve_Pc),
    .resolve_Target (resolve_Target),
    .resolve_Pred   (resolve_Pred),
    .branch_Result  (branch_Result),
    .mispredict     (mispredict),
    .redirect_Pc    (redirect_Pc)
`ifdef BRANCH_STATS_EN
    ,
    .stat_Branches    (stat_Branches),
    .stat_Mispredicts (stat_Mispredicts)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests_run = 0;
  int tests_failed = 0;

  // comb_q: {branch_Result, predict_Taken} checked mid-cycle.
  // seq_q:  {mispredict, redirect_Pc} checked just after the next rising edge.
  logic [1:0]  comb_q[$];
  logic [32:0] seq_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    if (comb_q.size() > 0) begin
      logic [1:0] e;
      e = comb_q.pop_front();
      check("branch_Result", {31'd0, branch_Result}, {31'd0, e[1]});
      check("predict_Taken", {31'd0, predict_Taken}, {31'd0, e[0]});
    end
  end

  always @(posedge clock) begin
    #1;
    if (seq_q.size() > 0) begin
      logic [32:0] e;
      e = seq_q.pop_front();
      check("mispredict", {31'd0, mispredict}, {31'd0, e[32]});
      check("redirect_Pc", redirect_Pc, e[31:0]);
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic [31:0] fpc, input logic br, input logic vld,
                       input logic [5:0] op, input logic [31:0] ula,
                       input logic [31:0] rpc, input logic [31:0] tgt, input logic pred);
    fetch_Pc       = fpc;
    branch         = br;
    resolve_Valid  = vld;
    op_Code        = op;
    ula_Result     = ula;
    resolve_Pc     = rpc;
    resolve_Target = tgt;
    resolve_Pred   = pred;
  endtask

  task automatic step(input logic [31:0] fpc, input logic br, input logic vld,
                      input logic [5:0] op, input logic [31:0] ula,
                      input logic [31:0] rpc, input logic [31:0] tgt, input logic pred,
                      input logic exp_br, input logic exp_pt,
                      input logic exp_mis, input logic [31:0] exp_redir);
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    drive(fpc, br, vld, op, ula, rpc, tgt, pred);
    comb_q.push_back({exp_br, exp_pt});
    seq_q.push_back({exp_mis, exp_redir});
  endtask

  task automatic idle(input logic [31:0] fpc, input logic exp_pt, input logic [31:0] exp_redir);
    step(fpc, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, exp_pt, 1'b0, exp_redir);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    drive(32'd0, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    #12;
    reset_n = 1'b1;
    #1;
    check("reset_predict", {31'd0, predict_Taken}, 32'd0);
    check("reset_mispredict", {31'd0, mispredict}, 32'd0);
    check("reset_redirect", redirect_Pc, 32'd0);

    //    fetch     br    vld   op       ula            rpc       tgt       pred  br_r  pt    mis   redir
    step(32'h40, 1'b1, 1'b1, OP_BEQ,  32'd0,         32'h40, 32'h100, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100);
    step(32'h40, 1'b0, 1'b1, OP_BEQ,  32'd0,         32'h40, 32'h100, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100);
    step(32'h80, 1'b1, 1'b1, OP_BNE,  32'd5,         32'h80, 32'h200, 1'b0, 1'b1, 1'b0, 1'b1, 32'h200);
    step(32'h80, 1'b1, 1'b1, OP_BNE,  32'd5,         32'h80, 32'h200, 1'b1, 1'b1, 1'b1, 1'b0, 32'h200);
    step(32'h80, 1'b1, 1'b1, OP_BNE,  32'd5,         32'h80, 32'h200, 1'b1, 1'b1, 1'b1, 1'b0, 32'h200);
    step(32'h80, 1'b1, 1'b1, OP_BNE,  32'd0,         32'h80, 32'h200, 1'b1, 1'b0, 1'b1, 1'b1, 32'h84);
    idle(32'h80, 1'b1, 32'h84);
    step(32'hC0, 1'b1, 1'b1, OP_BLEZ, 32'hFFFF_FFFF, 32'hC0, 32'h300, 1'b0, 1'b1, 1'b0, 1'b1, 32'h300);
    step(32'hC0, 1'b1, 1'b1, OP_BGTZ, 32'h8000_0000, 32'hD0, 32'h400, 1'b1, 1'b0, 1'b1, 1'b1, 32'hD4);
    step(32'hD0, 1'b1, 1'b1, OP_BLEZ, 32'd0,         32'hE0, 32'h500, 1'b1, 1'b1, 1'b0, 1'b0, 32'hD4);
    step(32'hE0, 1'b1, 1'b1, OP_BGTZ, 32'd1,         32'hF0, 32'h600, 1'b0, 1'b1, 1'b1, 1'b1, 32'h600);
    step(32'h40, 1'b1, 1'b1, 6'd0,    32'd0,         32'h40, 32'h700, 1'b1, 1'b0, 1'b1, 1'b0, 32'h600);
    step(32'h44, 1'b1, 1'b0, OP_BEQ,  32'd0,         32'h44, 32'h800, 1'b0, 1'b0, 1'b0, 1'b0, 32'h600);
    idle(32'h44, 1'b0, 32'h600);
    step(32'h48, 1'b1, 1'b1, OP_BEQ,  32'd0,         32'h48, 32'h900, 1'b1, 1'b1, 1'b0, 1'b0, 32'h600);
    idle(32'h48, 1'b1, 32'h600);
    step(32'h80, 1'b1, 1'b1, OP_BGTZ, 32'd1,         32'h80, 32'hA00, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA00);

    // Mispredicting resolve interrupted by an asynchronous reset before its edge.
    step(32'h80, 1'b1, 1'b1, OP_BEQ,  32'd0,         32'h40, 32'hB00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
`ifdef BRANCH_STATS_EN
    check("stat_branches", stat_Branches, 32'd11);
    check("stat_mispredicts", stat_Mispredicts, 32'd7);
`endif
    #4;
    reset_n = 1'b0;
    #1;
    check("async_mispredict", {31'd0, mispredict}, 32'd0);
    check("async_redirect", redirect_Pc, 32'd0);
    check("async_predict", {31'd0, predict_Taken}, 32'd0);
`ifdef BRANCH_STATS_EN
    check("reset_stat_branches", stat_Branches, 32'd0);
    check("reset_stat_mispredicts", stat_Mispredicts, 32'd0);
`endif

    idle(32'h80, 1'b0, 32'h0);
    idle(32'h40, 1'b0, 32'h0);
    idle(32'h48, 1'b0, 32'h0);
    idle(32'hC0, 1'b0, 32'h0);

    @(posedge clock);
    #3;
    check("comb_q_drained", comb_q.size(), 32'd0);
    check("seq_q_drained", seq_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
